// File: rtl/coherence_inval_engine.sv
// -----------------------------------------------------------------------------
// coherence_inval_engine
//
// Invalidation sequencer that sits after the coherence directory. For each
// write/upgrade request it sends one invalidation to every current sharer
// except the requester, in ascending L1 index order. It then collects the
// per-L1 acks and reports a completion. The directory uses that completion to
// make the requester the sole owner. One transaction is in flight at a time.
// A watchdog forces completion if acks stop arriving.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             request handshake: line index, requester id, sharer mask
//   inv_*             invalidation handshake: target L1 and line index
//   ack_vec           per-L1 single-cycle ack pulses (any number per cycle)
//   done_*            completion handshake: line, new owner mask, timeout flag
//   busy              high whenever a transaction is in progress
//
// All outputs are decoded from registered state only. There is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module coherence_inval_engine #(
  parameter  int N_LINES        = 1024,
  parameter  int N_SHARERS      = 8,
  parameter  int TIMEOUT_CYCLES = 1023,
  localparam int IDX_W          = $clog2(N_LINES),
  localparam int ID_W           = $clog2(N_SHARERS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDX_W-1:0]     req_line_idx,
  input  logic [ID_W-1:0]      req_id,
  input  logic [N_SHARERS-1:0] req_sharers,
  output logic                 inv_valid,
  input  logic                 inv_ready,
  output logic [ID_W-1:0]      inv_target,
  output logic [IDX_W-1:0]     inv_line_idx,
  input  logic [N_SHARERS-1:0] ack_vec,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [IDX_W-1:0]     done_line_idx,
  output logic [N_SHARERS-1:0] done_owner_mask,
  output logic                 done_timeout,
  output logic                 busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e               state_q,   state_d;
  logic [IDX_W-1:0]     line_q,    line_d;
  logic [ID_W-1:0]      id_q,      id_d;
  logic [N_SHARERS-1:0] send_q,    send_d;     // invalidations still to send
  logic [N_SHARERS-1:0] outst_q,   outst_d;    // sent, not yet acked
  logic [TMR_W-1:0]     timer_q,   timer_d;    // consecutive quiet WAIT cycles
  logic                 timeout_q, timeout_d;

  logic [ID_W-1:0]      cur_target;
  logic [N_SHARERS-1:0] cur_bit;
  logic                 inv_hs;

  // Lowest set bit of the send mask. The loop scans downward, so the last
  // match it finds is the lowest index. That gives ascending send order.
  always_comb begin
    cur_target = '0;
    for (int i = N_SHARERS - 1; i >= 0; i--) begin
      if (send_q[i]) cur_target = ID_W'(i);
    end
  end

  assign cur_bit = N_SHARERS'(1) << cur_target;
  assign inv_hs  = (state_q == ST_SEND) && inv_ready;

  // NOTE: every signal assigned in this block gets a default first. Otherwise
  // a path that skips the assignment would infer a latch.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    id_d      = id_q;
    send_d    = send_q;
    outst_d   = outst_q & ~ack_vec;   // acks retire outstanding bits in any state
    timer_d   = '0;                   // the timer only runs while waiting
    timeout_d = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          line_d    = req_line_idx;
          id_d      = req_id;
          send_d    = req_sharers & ~(N_SHARERS'(1) << req_id);
          outst_d   = '0;
          timeout_d = 1'b0;
          state_d   = (send_d != '0) ? ST_SEND : ST_DONE;
        end
      end

      ST_SEND: begin
        if (inv_hs) begin
          send_d  = send_q & ~cur_bit;
          // An ack that arrives in the same cycle as its handshake still counts.
          outst_d = (outst_q | cur_bit) & ~ack_vec;
          if (send_d == '0) state_d = (outst_d != '0) ? ST_WAIT : ST_DONE;
        end
      end

      ST_WAIT: begin
        if (outst_d == '0) begin
          state_d = ST_DONE;
        end else if ((outst_q & ack_vec) == '0) begin
          timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
          if (timer_d == TMR_MAX) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end
        end
        // If some bits were acked but others remain, timer_d keeps its default
        // of 0, which restarts the quiet-cycle count.
      end

      ST_DONE: begin
        if (done_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      line_q    <= '0;
      id_q      <= '0;
      send_q    <= '0;
      outst_q   <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      id_q      <= id_d;
      send_q    <= send_d;
      outst_q   <= outst_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  // Output decode. Payload fields are forced to 0 outside their owning state.
  assign req_ready       = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign inv_valid       = (state_q == ST_SEND);
  assign inv_target      = inv_valid ? cur_target : '0;
  assign inv_line_idx    = inv_valid ? line_q : '0;
  assign done_valid      = (state_q == ST_DONE);
  assign done_line_idx   = done_valid ? line_q : '0;
  assign done_owner_mask = done_valid ? (N_SHARERS'(1) << id_q) : '0;
  assign done_timeout    = done_valid && timeout_q;

endmodule

// File: tb/tb_coherence_inval_engine.sv
// -----------------------------------------------------------------------------
// tb_coherence_inval_engine
//
// Self-checking bench for coherence_inval_engine with TIMEOUT_CYCLES=16.
//
// The reference model works at the transaction level. It keeps a queue of
// targets still to send, a set of outstanding acks, a quiet-cycle count and a
// completion-pending flag. The model advances at each rising edge. A single
// compare process checks every DUT output against it on each falling edge.
//
// Directed scenarios first pin exact cycle behaviour with literal
// expectations. A long randomized run follows.
// -----------------------------------------------------------------------------
module tb_coherence_inval_engine;

  localparam int N_LINES = 1024;
  localparam int NS      = 8;
  localparam int TO      = 16;
  localparam int IDX_W   = 10;
  localparam int ID_W    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [IDX_W-1:0] req_line_idx = '0;
  logic [ID_W-1:0]  req_id = '0;
  logic [NS-1:0]    req_sharers = '0;
  logic             inv_valid;
  logic             inv_ready = 1'b0;
  logic [ID_W-1:0]  inv_target;
  logic [IDX_W-1:0] inv_line_idx;
  logic [NS-1:0]    ack_vec = '0;
  logic             done_valid;
  logic             done_ready = 1'b0;
  logic [IDX_W-1:0] done_line_idx;
  logic [NS-1:0]    done_owner_mask;
  logic             done_timeout;
  logic             busy;

  always #5 clk = ~clk;

  coherence_inval_engine #(
    .N_LINES        (N_LINES),
    .N_SHARERS      (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_line_idx    (req_line_idx),
    .req_id          (req_id),
    .req_sharers     (req_sharers),
    .inv_valid       (inv_valid),
    .inv_ready       (inv_ready),
    .inv_target      (inv_target),
    .inv_line_idx    (inv_line_idx),
    .ack_vec         (ack_vec),
    .done_valid      (done_valid),
    .done_ready      (done_ready),
    .done_line_idx   (done_line_idx),
    .done_owner_mask (done_owner_mask),
    .done_timeout    (done_timeout),
    .busy            (busy)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit               m_busy;
  int               m_q[$];      // targets still to invalidate, ascending
  bit [NS-1:0]      m_out;       // sent and awaiting ack
  int               m_quiet;     // consecutive waiting cycles without a retiring ack
  bit               m_done;      // completion being offered
  bit               m_to;
  logic [IDX_W-1:0] m_line;
  logic [ID_W-1:0]  m_id;

  function automatic void model_reset();
    m_busy = 0; m_q.delete(); m_out = '0; m_quiet = 0;
    m_done = 0; m_to = 0; m_line = '0; m_id = '0;
  endfunction

  // Advance one clock using the input values currently applied.
  function automatic void model_step();
    int t;
    bit cleared;
    if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1; m_line = req_line_idx; m_id = req_id;
        m_q.delete();
        for (int i = 0; i < NS; i++)
          if (req_sharers[i] && i != int'(req_id)) m_q.push_back(i);
        m_out = '0; m_quiet = 0; m_to = 0;
        m_done = (m_q.size() == 0);
      end
    end else if (m_done) begin
      if (done_ready) begin
        m_busy = 0; m_done = 0;
      end
    end else if (m_q.size() > 0) begin
      if (inv_ready) begin
        t = m_q.pop_front();
        m_out[t] = 1'b1;
      end
      m_out &= ~ack_vec;
      if (m_q.size() == 0 && m_out == '0) m_done = 1;
    end else begin
      cleared = |(m_out & ack_vec);
      m_out &= ~ack_vec;
      if (m_out == '0) m_done = 1;
      else if (cleared) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet >= TO) begin m_done = 1; m_to = 1; end
      end
    end
  endfunction

  // Single compare process: DUT outputs vs model on every falling edge.
  always @(negedge clk) begin
    logic             e_iv;
    logic [ID_W-1:0]  e_it;
    logic [IDX_W-1:0] e_il;
    if (cmp_en) begin
      e_iv = m_busy && !m_done && (m_q.size() > 0);
      e_it = '0;
      e_il = '0;
      if (e_iv) begin
        e_it = ID_W'(m_q[0]);
        e_il = m_line;
      end
      check("model req_ready/busy", {62'd0, req_ready, busy}, {62'd0, !m_busy, m_busy});
      check("model inv", {50'd0, inv_valid, inv_target, inv_line_idx}, {50'd0, e_iv, e_it, e_il});
      check("model done",
            {44'd0, done_valid, done_line_idx, done_owner_mask, done_timeout},
            {44'd0, m_done, m_done ? m_line : 10'd0,
             m_done ? NS'(1) << m_id : NS'(0), m_done && m_to});
    end
  end

  // Apply inputs for one cycle. The model advances at the edge, and the task
  // returns 1 time unit after it, when DUT outputs are settled for sampling.
  task automatic step(input bit rv, input logic [IDX_W-1:0] li, input logic [ID_W-1:0] id,
                      input logic [NS-1:0] sh, input bit ir, input logic [NS-1:0] av,
                      input bit dr);
    req_valid = rv; req_line_idx = li; req_id = id; req_sharers = sh;
    inv_ready = ir; ack_vec = av; done_ready = dr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_step(input bit ir, input logic [NS-1:0] av, input bit dr);
    step(1'b0, '0, '0, '0, ir, av, dr);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {req_ready, busy, inv_valid, inv_target, inv_line_idx, done_valid,
                 done_line_idx, done_owner_mask, done_timeout},
          {1'b1, 35'd0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit silent;
    logic [ID_W-1:0] rid;
    logic [NS-1:0]   rsh;

    model_reset();
    #12;
    check_reset_outputs("reset outputs");
    cmp_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: sharers 1011_0010, requester 1 -> targets 4,5,7, each acked with its handshake
    step(1, 10'h155, 3'd1, 8'b1011_0010, 1, 8'h00, 0);
    check("t1 first inv", {inv_valid, inv_target, inv_line_idx}, {1'b1, 3'd4, 10'h155});
    idle_step(1, 8'h10, 0);
    check("t1 second inv", {inv_valid, inv_target}, {1'b1, 3'd5});
    idle_step(1, 8'h20, 0);
    check("t1 third inv", {inv_valid, inv_target}, {1'b1, 3'd7});
    idle_step(1, 8'h80, 0);
    check("t1 done", {done_valid, done_owner_mask, done_timeout, done_line_idx},
          {1'b1, 8'b0000_0010, 1'b0, 10'h155});
    idle_step(0, 8'h00, 1);
    check("t1 back idle", {req_ready, busy}, 2'b10);

    // 2: only the requester shares -> completion the cycle after acceptance
    step(1, 10'h2A0, 3'd2, 8'b0000_0100, 1, 8'h00, 0);
    check("t2 done next cycle", {done_valid, inv_valid, done_owner_mask},
          {1'b1, 1'b0, 8'b0000_0100});
    idle_step(0, 8'h00, 1);

    // 3: sharers {0,3}, inv_ready held low 5 cycles -> target 0 stays stable
    step(1, 10'h077, 3'd5, 8'h09, 0, 8'h00, 0);
    for (int k = 0; k < 5; k++) begin
      check("t3 stall stable", {inv_valid, inv_target, inv_line_idx}, {1'b1, 3'd0, 10'h077});
      idle_step(0, 8'h00, 0);
    end
    idle_step(1, 8'h00, 0);
    check("t3 then target 3", {inv_valid, inv_target}, {1'b1, 3'd3});

    // 4: ack_vec=FF before target 3 is sent -> 0 retired, 3 still sent and awaited
    idle_step(0, 8'hFF, 0);
    check("t4 target 3 kept", {inv_valid, inv_target}, {1'b1, 3'd3});
    idle_step(1, 8'h00, 0);
    check("t4 waiting", {busy, inv_valid, done_valid}, 3'b100);
    idle_step(0, 8'h00, 0);
    idle_step(0, 8'h00, 0);
    check("t4 still waiting", done_valid, 1'b0);
    idle_step(0, 8'h08, 0);
    check("t4 done", {done_valid, done_timeout, done_owner_mask}, {1'b1, 1'b0, 8'h20});
    idle_step(0, 8'h00, 1);

    // 5: target 6 never acks -> forced completion 16 cycles after entering WAIT
    step(1, 10'h3FF, 3'd0, 8'h40, 1, 8'h00, 0);
    idle_step(1, 8'h00, 0);   // handshake for target 6; WAIT starts after this edge
    for (int k = 1; k < TO; k++) begin
      idle_step(0, 8'h00, 0);
      check("t5 no early done", done_valid, 1'b0);
    end
    idle_step(0, 8'h00, 0);
    check("t5 timeout done", {done_valid, done_timeout, done_line_idx, done_owner_mask},
          {1'b1, 1'b1, 10'h3FF, 8'h01});

    // 6: done_ready low for 4 cycles -> payload held, no new request accepted
    for (int k = 0; k < 4; k++) begin
      step(1, 10'h111, 3'd4, 8'hFF, 0, 8'h00, 0);
      check("t6 held", {req_ready, done_valid, done_timeout, done_line_idx, done_owner_mask},
            {1'b0, 1'b1, 1'b1, 10'h3FF, 8'h01});
    end
    idle_step(0, 8'h00, 1);
    check("t6 released", req_ready, 1'b1);

    // 6b: reset while waiting aborts the transaction
    step(1, 10'h0C3, 3'd0, 8'h06, 1, 8'h00, 0);
    idle_step(1, 8'h00, 0);
    idle_step(1, 8'h00, 0);
    idle_step(0, 8'h00, 0);
    check("t6b in wait", {busy, inv_valid, done_valid}, 3'b100);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("t6b reset outputs");
    @(posedge clk); #1;
    check_reset_outputs("t6b reset held");
    rst_n = 1'b1;
    idle_step(0, 8'h00, 0);
    check("t6b no done after reset", {req_ready, done_valid}, 2'b10);

    // Randomized traffic
    silent = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 97 == 0) silent = ($urandom_range(0, 4) == 0);
      rid = ID_W'($urandom);
      rsh = NS'($urandom);
      if ($urandom_range(0, 7) == 0) rsh = NS'(1) << rid;
      step($urandom_range(0, 1) == 1, IDX_W'($urandom), rid, rsh,
           $urandom_range(0, 9) < 7,
           silent ? NS'(0) : (($urandom_range(0, 2) == 0) ? NS'($urandom) : NS'(0)),
           $urandom_range(0, 9) < 6);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
